// File: rtl/ucie_ctl_sb_tx_multi_cred_fsm.sv
// Sideband TX controller: sequences header/data phases into the SB shifter,
// tracks outstanding pl_cfg credits and queues one request arriving while busy.
module ucie_ctl_sb_tx_multi_cred_fsm #(
    parameter int NC       = 32,
    parameter int HDR_W    = 64,
    parameter int DATA_W   = 64,
    parameter int CRED_MAX = 4,
    localparam int HDR_PH  = HDR_W / NC,
    localparam int DATA_PH = DATA_W / NC,
    localparam int PH_W    = ((HDR_PH + DATA_PH) > 1) ? $clog2(HDR_PH + DATA_PH) : 1,
    localparam int CRED_W  = $clog2(CRED_MAX + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid_lp_sb,
    input  logic              i_ignore_data2,
    input  logic              i_done_shift,
    input  logic              i_rdi_pl_cfg_cred,
    output logic              o_pl_sb_busy,
    output logic [1:0]        o_buf_en,
    output logic [1:0]        o_shift_load,
    output logic [PH_W-1:0]   o_phase_sel,
    output logic              o_en_analyser,
    output logic              o_lp_cfg_vld,
    output logic [CRED_W-1:0] o_cred_avail,
    output logic              o_cred_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_NO_CRED = 2'd1,
        ST_LOAD    = 2'd2,
        ST_SEND    = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic              pending_r, pending_s;
    logic              valid_q_r;
    logic [CRED_W-1:0] cred_r, cred_s;
    logic              cred_err_r, cred_err_s;
    logic [PH_W-1:0]   ph_r, ph_s;
    logic [PH_W-1:0]   last_ph_r, last_ph_s;
    logic              load_cyc_r, load_cyc_s;
    logic              rise_s;
    logic              consume_s;

    // State and counter registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r    <= ST_IDLE;
            pending_r  <= 1'b0;
            valid_q_r  <= 1'b0;
            cred_r     <= CRED_W'(CRED_MAX);
            cred_err_r <= 1'b0;
            ph_r       <= '0;
            last_ph_r  <= '0;
            load_cyc_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            pending_r  <= pending_s;
            valid_q_r  <= i_valid_lp_sb;
            cred_r     <= cred_s;
            cred_err_r <= cred_err_s;
            ph_r       <= ph_s;
            last_ph_r  <= last_ph_s;
            load_cyc_r <= load_cyc_s;
        end
    end

    // Credit counter: a consume and a return in the same cycle cancel out
    always_comb begin
        rise_s     = i_valid_lp_sb & ~valid_q_r;
        consume_s  = (state_r == ST_LOAD);
        cred_s     = cred_r;
        cred_err_s = 1'b0;
        case ({consume_s, i_rdi_pl_cfg_cred})
            2'b10: cred_s = cred_r - CRED_W'(1);
            2'b01: begin
                if (cred_r == CRED_W'(CRED_MAX)) begin
                    cred_err_s = 1'b1;
                end else begin
                    cred_s = cred_r + CRED_W'(1);
                end
            end
            default: cred_s = cred_r;
        endcase
    end

    // Next-state logic; NO_CRED also sees a credit returned this very cycle
    always_comb begin
        state_s    = state_r;
        pending_s  = pending_r;
        ph_s       = ph_r;
        last_ph_s  = last_ph_r;
        load_cyc_s = load_cyc_r;
        case (state_r)
            ST_IDLE: begin
                if (rise_s | pending_r) begin
                    pending_s = 1'b0;
                    state_s   = (cred_r != '0) ? ST_LOAD : ST_NO_CRED;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_NO_CRED: begin
                if ((cred_r != '0) || i_rdi_pl_cfg_cred) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_NO_CRED;
                end
            end
            ST_LOAD: begin
                if (i_ignore_data2) begin
                    last_ph_s = PH_W'(HDR_PH - 1);
                end else begin
                    last_ph_s = PH_W'(HDR_PH + DATA_PH - 1);
                end
                ph_s       = '0;
                load_cyc_s = 1'b1;
                state_s    = ST_SEND;
            end
            ST_SEND: begin
                if (load_cyc_r) begin
                    load_cyc_s = 1'b0;
                end else if (i_done_shift) begin
                    if (ph_r < last_ph_r) begin
                        ph_s       = ph_r + PH_W'(1);
                        load_cyc_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    load_cyc_s = 1'b0;
                end
            end
            default: state_s = ST_IDLE;
        endcase
        // Only one request can be queued; later rises are dropped
        if ((state_r != ST_IDLE) && rise_s) begin
            pending_s = 1'b1;
        end else begin
            pending_s = pending_s;
        end
    end

    // Output decode from registered state
    always_comb begin
        o_pl_sb_busy  = (state_r != ST_IDLE) | pending_r;
        o_buf_en      = (state_r == ST_LOAD) ? {~i_ignore_data2, 1'b1} : 2'b00;
        o_shift_load  = 2'b00;
        o_phase_sel   = '0;
        if (state_r == ST_SEND) begin
            o_shift_load = load_cyc_r ? 2'b01 : 2'b10;
            o_phase_sel  = ph_r;
        end else begin
            o_shift_load = 2'b00;
            o_phase_sel  = '0;
        end
        o_en_analyser = (state_r == ST_LOAD);
        o_lp_cfg_vld  = (state_r == ST_SEND);
        o_cred_avail  = cred_r;
        o_cred_err    = cred_err_r;
    end

endmodule

// File: tb/tb_ucie_ctl_sb_tx_multi_cred_fsm.sv
// Directed bench for the sideband TX controller: default instance (CRED_MAX=4)
// plus a CRED_MAX=1 instance for the credit-starved path.
module tb_ucie_ctl_sb_tx_multi_cred_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0, ignore = 1'b0, done = 1'b0, ret = 1'b0;
    logic       valid1 = 1'b0, ret1 = 1'b0;

    logic       busy, en_an, lp_vld, cred_err;
    logic [1:0] buf_en, shift_load, phase_sel;
    logic [2:0] cred;

    logic       b_busy, b_en_an, b_lp_vld, b_cred_err;
    logic [1:0] b_buf_en, b_shift_load, b_phase_sel;
    logic [0:0] b_cred;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    ucie_ctl_sb_tx_multi_cred_fsm dut (
        .i_clk(clk), .i_rst(rst), .i_valid_lp_sb(valid), .i_ignore_data2(ignore),
        .i_done_shift(done), .i_rdi_pl_cfg_cred(ret), .o_pl_sb_busy(busy),
        .o_buf_en(buf_en), .o_shift_load(shift_load), .o_phase_sel(phase_sel),
        .o_en_analyser(en_an), .o_lp_cfg_vld(lp_vld), .o_cred_avail(cred),
        .o_cred_err(cred_err)
    );

    ucie_ctl_sb_tx_multi_cred_fsm #(.CRED_MAX(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid_lp_sb(valid1), .i_ignore_data2(ignore),
        .i_done_shift(done), .i_rdi_pl_cfg_cred(ret1), .o_pl_sb_busy(b_busy),
        .o_buf_en(b_buf_en), .o_shift_load(b_shift_load), .o_phase_sel(b_phase_sel),
        .o_en_analyser(b_en_an), .o_lp_cfg_vld(b_lp_vld), .o_cred_avail(b_cred),
        .o_cred_err(b_cred_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One phase of the default instance: load, shift, shift with done
    task automatic phase(input int ph, input bit done_in_load);
        chk("ph_load", 32'(shift_load), 32'h1);
        chk("ph_sel", 32'(phase_sel), 32'(ph));
        chk("ph_vld", 32'(lp_vld), 32'h1);
        done = done_in_load;
        tick();
        done = 1'b0;
        chk("ph_shift1", 32'(shift_load), 32'h2);
        chk("ph_sel1", 32'(phase_sel), 32'(ph));
        tick();
        chk("ph_shift2", 32'(shift_load), 32'h2);
        chk("ph_vld2", 32'(lp_vld), 32'h1);
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_buf", 32'(buf_en), 32'h0);
        chk("rst_shift", 32'(shift_load), 32'h0);
        chk("rst_vld", 32'(lp_vld), 32'h0);
        chk("rst_cred", 32'(cred), 32'h4);
        chk("rst_cred1", 32'(b_cred), 32'h1);
        rst = 1'b0;
        tick();

        // Test 3: CRED_MAX=1 instance, starve then return a credit
        ignore = 1'b1;
        valid1 = 1'b1;
        tick();
        valid1 = 1'b0;
        chk("t3_load_en", 32'(b_en_an), 32'h1);
        chk("t3_load_buf", 32'(b_buf_en), 32'h1);
        chk("t3_load_cred", 32'(b_cred), 32'h1);
        tick();
        chk("t3_send_cred", 32'(b_cred), 32'h0);
        chk("t3_send_ld", 32'(b_shift_load), 32'h1);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("t3_ph1_sel", 32'(b_phase_sel), 32'h1);
        chk("t3_ph1_ld", 32'(b_shift_load), 32'h1);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("t3_idle_busy", 32'(b_busy), 32'h0);
        chk("t3_idle_vld", 32'(b_lp_vld), 32'h0);
        valid1 = 1'b1;
        tick();
        valid1 = 1'b0;
        chk("t3_nc_busy", 32'(b_busy), 32'h1);
        chk("t3_nc_shift", 32'(b_shift_load), 32'h0);
        chk("t3_nc_en", 32'(b_en_an), 32'h0);
        chk("t3_nc_buf", 32'(b_buf_en), 32'h0);
        chk("t3_nc_vld", 32'(b_lp_vld), 32'h0);
        tick();
        chk("t3_nc_hold", 32'(b_busy), 32'h1);
        chk("t3_nc_hold_en", 32'(b_en_an), 32'h0);
        ret1 = 1'b1;
        tick();
        ret1 = 1'b0;
        chk("t3_ret_load", 32'(b_en_an), 32'h1);
        chk("t3_ret_cred", 32'(b_cred), 32'h1);
        tick();
        chk("t3_send2_cred", 32'(b_cred), 32'h0);
        chk("t3_send2_vld", 32'(b_lp_vld), 32'h1);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("t3_end_busy", 32'(b_busy), 32'h0);
        ignore = 1'b0;

        // Test 1: full packet, 4 phases
        valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("t1_load_busy", 32'(busy), 32'h1);
        chk("t1_load_buf", 32'(buf_en), 32'h3);
        chk("t1_load_en", 32'(en_an), 32'h1);
        chk("t1_load_shift", 32'(shift_load), 32'h0);
        chk("t1_load_vld", 32'(lp_vld), 32'h0);
        chk("t1_load_cred", 32'(cred), 32'h4);
        tick();
        chk("t1_send_cred", 32'(cred), 32'h3);
        chk("t1_send_en", 32'(en_an), 32'h0);
        phase(0, 1'b1);
        phase(1, 1'b0);
        phase(2, 1'b0);
        phase(3, 1'b0);
        chk("t1_end_vld", 32'(lp_vld), 32'h0);
        chk("t1_end_busy", 32'(busy), 32'h0);
        chk("t1_end_shift", 32'(shift_load), 32'h0);
        chk("t1_end_cred", 32'(cred), 32'h3);

        // Test 2: header only
        ignore = 1'b1;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("t2_load_buf", 32'(buf_en), 32'h1);
        tick();
        phase(0, 1'b0);
        phase(1, 1'b0);
        chk("t2_end_vld", 32'(lp_vld), 32'h0);
        chk("t2_end_busy", 32'(busy), 32'h0);
        chk("t2_end_cred", 32'(cred), 32'h2);

        // Test 4: rises during SEND queue exactly one packet
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        chk("t4_send_cred", 32'(cred), 32'h1);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("t4_pend_busy", 32'(busy), 32'h1);
        chk("t4_pend_shift", 32'(shift_load), 32'h2);
        tick();
        valid = 1'b1;
        done = 1'b1;
        tick();
        valid = 1'b0;
        done = 1'b0;
        chk("t4_ph1_ld", 32'(shift_load), 32'h1);
        chk("t4_ph1_sel", 32'(phase_sel), 32'h1);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("t4_idle_busy", 32'(busy), 32'h1);
        chk("t4_idle_shift", 32'(shift_load), 32'h0);
        chk("t4_idle_vld", 32'(lp_vld), 32'h0);
        chk("t4_idle_en", 32'(en_an), 32'h0);
        tick();
        chk("t4_q_load", 32'(en_an), 32'h1);
        chk("t4_q_cred", 32'(cred), 32'h1);
        tick();
        chk("t4_q_cred2", 32'(cred), 32'h0);
        phase(0, 1'b0);
        phase(1, 1'b0);
        chk("t4_end_busy", 32'(busy), 32'h0);
        tick();
        chk("t4_lost_busy", 32'(busy), 32'h0);
        chk("t4_lost_en", 32'(en_an), 32'h0);

        // Test 5: return with LOAD, then saturation
        ret = 1'b1;
        tick();
        ret = 1'b0;
        chk("t5_ret_cred", 32'(cred), 32'h1);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        ret = 1'b1;
        tick();
        ret = 1'b0;
        chk("t5_cancel_cred", 32'(cred), 32'h1);
        phase(0, 1'b0);
        phase(1, 1'b0);
        chk("t5_pkt_cred", 32'(cred), 32'h1);
        ret = 1'b1;
        tick();
        tick();
        tick();
        chk("t5_full_cred", 32'(cred), 32'h4);
        chk("t5_full_err", 32'(cred_err), 32'h0);
        tick();
        ret = 1'b0;
        chk("t5_sat_cred", 32'(cred), 32'h4);
        chk("t5_sat_err", 32'(cred_err), 32'h1);
        tick();
        chk("t5_err_clr", 32'(cred_err), 32'h0);
        chk("t5_err_cred", 32'(cred), 32'h4);

        // Test 6: reset in phase 2 aborts the packet
        ignore = 1'b0;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        chk("t6_send_cred", 32'(cred), 32'h3);
        phase(0, 1'b0);
        phase(1, 1'b0);
        chk("t6_ph2_sel", 32'(phase_sel), 32'h2);
        tick();
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'h0);
        chk("t6_rst_shift", 32'(shift_load), 32'h0);
        chk("t6_rst_sel", 32'(phase_sel), 32'h0);
        chk("t6_rst_vld", 32'(lp_vld), 32'h0);
        chk("t6_rst_cred", 32'(cred), 32'h4);
        chk("t6_rst_err", 32'(cred_err), 32'h0);
        done = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("t6_post_shift", 32'(shift_load), 32'h0);
        chk("t6_post_vld", 32'(lp_vld), 32'h0);
        chk("t6_post_busy", 32'(busy), 32'h0);
        done = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
